// File: rtl/mbufgce_ctrl_pkg.sv
// Shared state encoding for the MBUFGCE control sequencer.
package mbufgce_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_CLEAR   = 3'd0,
        ST_RELEASE = 3'd1,
        ST_OFF     = 3'd2,
        ST_ON      = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

endpackage

// File: rtl/mbufgce_ctrl_timer.sv
// Loadable down-counter that saturates at zero; zero flag is combinational from the count.
module mbufgce_ctrl_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mbufgce_ctrl.sv
// Sequences CE / CLRB_LEAF of the MBUFGCE wrapper: enable/disable handshake and divider resync.
// All outputs are Moore decodes registered on the same edge as the state.
module mbufgce_ctrl
    import mbufgce_ctrl_pkg::*;
#(
    parameter int CLR_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_req,
    input  logic               resync_req,
    output logic               ce,
    output logic               clr_n,
    output logic               en_ack,
    output logic               busy,
    output logic               resync_done,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [CNT_W-1:0] CLR_LOAD    = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           nxt;
    logic             flag;
    logic             flag_nxt;
    logic             done_nxt;
    logic             tmr_zero;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;

    mbufgce_ctrl_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // A resync request in any state only sets the flag; the state decides when it acts.
    always_comb begin
        nxt      = state;
        flag_nxt = flag | resync_req;
        done_nxt = 1'b0;
        unique case (state)
            ST_CLEAR: begin
                if (tmr_zero) nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (tmr_zero) begin
                    nxt      = en_req ? ST_ON : ST_OFF;
                    done_nxt = flag_nxt;
                    flag_nxt = 1'b0;
                end
            end
            ST_OFF: begin
                if (resync_req)  nxt = ST_CLEAR;
                else if (en_req) nxt = ST_ON;
            end
            ST_ON: begin
                if (resync_req || !en_req) nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (tmr_zero) nxt = flag_nxt ? ST_CLEAR : ST_OFF;
            end
            default: nxt = ST_CLEAR;
        endcase
    end

    assign tmr_load = rst || (nxt != state);
    assign tmr_val  = (rst || nxt == ST_CLEAR) ? CLR_LOAD : SETTLE_LOAD;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_CLEAR;
            flag        <= 1'b0;
            ce          <= 1'b0;
            clr_n       <= 1'b0;
            en_ack      <= 1'b0;
            busy        <= 1'b1;
            resync_done <= 1'b0;
        end else begin
            state       <= nxt;
            flag        <= flag_nxt;
            ce          <= (nxt == ST_ON);
            clr_n       <= (nxt != ST_CLEAR);
            en_ack      <= (nxt == ST_ON);
            busy        <= (nxt == ST_CLEAR) || (nxt == ST_RELEASE) || (nxt == ST_DRAIN);
            resync_done <= done_nxt;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_mbufgce_ctrl.sv
// Directed bench: stimulus queues the expected output vector for each cycle, a monitor compares after each edge.
module tb_mbufgce_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_req;
    logic       resync_req;
    logic       ce;
    logic       clr_n;
    logic       en_ack;
    logic       busy;
    logic       resync_done;
    logic [2:0] state_o;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    // Expected vector: {state, ce, clr_n, en_ack, busy, resync_done}
    localparam logic [7:0] E_CLR   = {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [7:0] E_REL   = {3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [7:0] E_OFF   = {3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [7:0] E_ON    = {3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic [7:0] E_DRN   = {3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [7:0] E_ON_D  = {3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam logic [7:0] E_OFF_D = {3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    mbufgce_ctrl #(
        .CLR_CYCLES    (4),
        .SETTLE_CYCLES (8),
        .CNT_W         (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_req      (en_req),
        .resync_req  (resync_req),
        .ce          (ce),
        .clr_n       (clr_n),
        .en_ack      (en_ack),
        .busy        (busy),
        .resync_done (resync_done),
        .state_o     (state_o)
    );

    // n cycles of constant inputs (resync only on the first), each expecting `ex` after its edge.
    task automatic run(input int n, input logic r, input logic e, input logic rs,
                       input logic [7:0] ex, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst        = r;
            en_req     = e;
            resync_req = (i == 0) ? rs : 1'b0;
            exp_q.push_back(ex);
            tag_q.push_back($sformatf("%s[%0d]", tag, i));
        end
    endtask

    initial begin : monitor
        logic [7:0] act;
        logic [7:0] ex;
        string      tag;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                ex  = exp_q.pop_front();
                tag = tag_q.pop_front();
                act = {state_o, ce, clr_n, en_ack, busy, resync_done};
                tests++;
                if (act !== ex) begin
                    fails++;
                    $display("FAIL %s: got st=%0d ce=%b clr_n=%b ack=%b busy=%b done=%b, want st=%0d ce=%b clr_n=%b ack=%b busy=%b done=%b",
                             tag, act[7:5], act[4], act[3], act[2], act[1], act[0],
                             ex[7:5], ex[4], ex[3], ex[2], ex[1], ex[0]);
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b1;
        en_req = 1'b0;
        resync_req = 1'b0;

        // Reset and power-up clear
        run(3, 1, 0, 0, E_CLR, "rst");
        run(3, 0, 0, 0, E_CLR, "pu_clear");
        run(8, 0, 0, 0, E_REL, "pu_release");
        run(2, 0, 0, 0, E_OFF, "pu_off");

        // Plain enable / disable
        run(4, 0, 1, 0, E_ON,  "enable");
        run(8, 0, 0, 0, E_DRN, "disable_drain");
        run(2, 0, 0, 0, E_OFF, "disable_off");

        // Resync with en_req held high
        run(2, 0, 1, 0, E_ON,   "on_a");
        run(8, 0, 1, 1, E_DRN,  "rs_drain");
        run(4, 0, 1, 0, E_CLR,  "rs_clear");
        run(8, 0, 1, 0, E_REL,  "rs_release");
        run(1, 0, 1, 0, E_ON_D, "rs_done");
        run(2, 0, 1, 0, E_ON,   "rs_on");

        // Resync and disable in the same cycle
        run(8, 0, 0, 1, E_DRN,   "rsoff_drain");
        run(4, 0, 0, 0, E_CLR,   "rsoff_clear");
        run(8, 0, 0, 0, E_REL,   "rsoff_release");
        run(1, 0, 0, 0, E_OFF_D, "rsoff_done");
        run(2, 0, 0, 0, E_OFF,   "rsoff_off");

        // Reset in cycle 3 of RELEASE during a resync
        run(2, 0, 1, 0, E_ON,  "on_b");
        run(8, 0, 1, 1, E_DRN, "rr_drain");
        run(4, 0, 1, 0, E_CLR, "rr_clear");
        run(2, 0, 1, 0, E_REL, "rr_release");
        run(1, 1, 1, 0, E_CLR, "rr_rst");
        run(3, 0, 1, 0, E_CLR, "rr_clear2");
        run(8, 0, 1, 0, E_REL, "rr_release2");
        run(2, 0, 1, 0, E_ON,  "rr_on_nodone");

        // Extra resync pulses in DRAIN cycle 2 and CLEAR cycle 1 are absorbed
        run(1, 0, 1, 1, E_DRN,  "dbl_drain1");
        run(1, 0, 1, 1, E_DRN,  "dbl_drain2");
        run(6, 0, 1, 0, E_DRN,  "dbl_drain3");
        run(1, 0, 1, 1, E_CLR,  "dbl_clear1");
        run(3, 0, 1, 0, E_CLR,  "dbl_clear2");
        run(8, 0, 1, 0, E_REL,  "dbl_release");
        run(1, 0, 1, 0, E_ON_D, "dbl_done");
        run(3, 0, 1, 0, E_ON,   "dbl_on");

        @(negedge clk);
        resync_req = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_queue: %0d expectations unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
